// File: rtl/prover_adder_tree_feeder_if.sv
// Bundle between the adder-tree feeder and its job source, tree and
// result consumer; slave is the feeder's view, master the environment's.
interface prover_adder_tree_feeder_if #(
  parameter int F_NBITS = 32,
  parameter int ngates  = 8,
  parameter int ntagb   = 8
);
  logic                        start;
  logic [ntagb-1:0]            nsums;
  logic                        src_valid;
  logic                        src_ready;
  logic [F_NBITS*ngates-1:0]   src_data;
  logic                        tree_en;
  logic [F_NBITS*ngates-1:0]   tree_in;
  logic [ntagb-1:0]            tree_in_tag;
  logic                        tree_in_ready;
  logic                        tree_in_ready_pulse;
  logic                        tree_out_ready_pulse;
  logic [F_NBITS-1:0]          tree_out;
  logic [ntagb-1:0]            tree_out_tag;
  logic                        res_valid;
  logic [F_NBITS-1:0]          res_data;
  logic [ntagb-1:0]            res_tag;
  logic                        busy;
  logic                        done_pulse;
  logic                        tag_err;

  modport slave (
    input  start,
    input  nsums,
    input  src_valid,
    output src_ready,
    input  src_data,
    output tree_en,
    output tree_in,
    output tree_in_tag,
    input  tree_in_ready,
    input  tree_in_ready_pulse,
    input  tree_out_ready_pulse,
    input  tree_out,
    input  tree_out_tag,
    output res_valid,
    output res_data,
    output res_tag,
    output busy,
    output done_pulse,
    output tag_err
  );

  modport master (
    output start,
    output nsums,
    output src_valid,
    input  src_ready,
    output src_data,
    input  tree_en,
    input  tree_in,
    input  tree_in_tag,
    output tree_in_ready,
    output tree_in_ready_pulse,
    output tree_out_ready_pulse,
    output tree_out,
    output tree_out_tag,
    input  res_valid,
    input  res_data,
    input  res_tag,
    input  busy,
    input  done_pulse,
    input  tag_err
  );
endinterface

// File: rtl/prover_adder_tree_feeder.sv
// Issue sequencer and result collector for the pipelined prover adder tree.
// Optional tag-order checker enabled by PROVER_ADDER_FEEDER_TAGCHK_EN.
module prover_adder_tree_feeder #(
  parameter int F_NBITS = 32,
  parameter int ngates  = 8,
  parameter int ntagb   = 8
) (
  input  logic                      clk,
  input  logic                      rstb,
  prover_adder_tree_feeder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_e;

  state_e state_q;
  state_e state_d;

  logic [ntagb-1:0]   nsums_q;
  logic [ntagb-1:0]   nsums_d;
  logic [ntagb-1:0]   issue_cnt_q;
  logic [ntagb-1:0]   issue_cnt_d;
  logic [ntagb-1:0]   coll_cnt_q;
  logic [ntagb-1:0]   coll_cnt_d;
  logic               busy_q;
  logic               busy_d;
  logic               done_q;
  logic               done_d;
  logic               res_valid_q;
  logic               res_valid_d;
  logic [F_NBITS-1:0] res_data_q;
  logic [F_NBITS-1:0] res_data_d;
  logic [ntagb-1:0]   res_tag_q;
  logic [ntagb-1:0]   res_tag_d;

  logic [F_NBITS*ngates-1:0] vec_w;

  logic start_acc;
  logic start_zero;
  logic src_ready_c;
  logic tree_en_c;
  logic xfer;
  logic last_issue;
  logic cap;
  logic last_cap;

  // Only an idle feeder takes a job; busy covers the collect-only tail.
  assign start_acc  = bus.start & ~busy_q & (state_q == S_IDLE);
  assign start_zero = start_acc & (bus.nsums == '0);

  assign xfer       = bus.src_valid & src_ready_c;
  assign last_issue = (issue_cnt_q + ntagb'(1)) == nsums_q;

  assign cap        = bus.tree_out_ready_pulse & busy_q;
  assign last_cap   = cap & ((coll_cnt_q + ntagb'(1)) == nsums_q);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pacing pulses only count in WAIT, never in the transfer cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_acc && !start_zero) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (xfer) begin
          state_d = last_issue ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.tree_in_ready_pulse) begin
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    src_ready_c = 1'b0;
    tree_en_c   = 1'b0;
    unique case (1'b1)
      (state_q == S_ISSUE): begin
        src_ready_c = bus.tree_in_ready;
        tree_en_c   = bus.src_valid & bus.tree_in_ready;
      end
      default: begin
        src_ready_c = 1'b0;
        tree_en_c   = 1'b0;
      end
    endcase
  end

  always_comb begin
    nsums_d     = nsums_q;
    issue_cnt_d = issue_cnt_q;
    coll_cnt_d  = coll_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    res_valid_d = cap;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;

    if (start_acc) begin
      nsums_d     = bus.nsums;
      issue_cnt_d = '0;
      coll_cnt_d  = '0;
      busy_d      = ~start_zero;
      done_d      = start_zero;
    end else begin
      if (xfer) begin
        issue_cnt_d = issue_cnt_q + ntagb'(1);
      end
      if (cap) begin
        coll_cnt_d = coll_cnt_q + ntagb'(1);
        res_data_d = bus.tree_out;
        res_tag_d  = bus.tree_out_tag;
      end
      if (last_cap) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      nsums_q     <= '0;
      issue_cnt_q <= '0;
      coll_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
    end else begin
      nsums_q     <= nsums_d;
      issue_cnt_q <= issue_cnt_d;
      coll_cnt_q  <= coll_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
    end
  end

`ifdef PROVER_ADDER_FEEDER_TAGCHK_EN
  logic tag_err_q;
  logic tag_err_d;

  // Sticky until the next accepted job; results pass through regardless.
  always_comb begin
    tag_err_d = tag_err_q;
    if (start_acc) begin
      tag_err_d = 1'b0;
    end else if (cap && (bus.tree_out_tag != coll_cnt_q)) begin
      tag_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      tag_err_q <= 1'b0;
    end else begin
      tag_err_q <= tag_err_d;
    end
  end

  assign bus.tag_err = tag_err_q;
`else
  assign bus.tag_err = 1'b0;
`endif

  assign vec_w           = bus.src_data;
  assign bus.tree_in     = vec_w;
  assign bus.tree_in_tag = issue_cnt_q;
  assign bus.tree_en     = tree_en_c;
  assign bus.src_ready   = src_ready_c;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_tag     = res_tag_q;
  assign bus.busy        = busy_q;
  assign bus.done_pulse  = done_q;

endmodule
